// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-to-UART transmitter.
// Optional macro FIFO_UART_TX_PARITY_EN adds the even-parity state to the FSM.
package fifo_uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StStart,
        StData,
        StStop
    } tx_state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the synchronous FIFO and the UART transmitter.
// The master is the consumer that issues fifo_r_en; the slave is the FIFO.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic                 fifo_empty;
    logic                 fifo_r_en;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_valid;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  fifo_valid,
        output fifo_r_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output fifo_valid,
        input  fifo_r_en
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: tick_o is high on the last clock of each CLKS_PER_BIT period.
// clear_i restarts the period so every state begins on a fresh bit boundary.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO one byte at a time and serialises it as UART 8N1 (8E1 when
// FIFO_UART_TX_PARITY_EN is defined), LSB first, on a registered txd line.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tx_en_i,
    fifo_uart_tx_if.master fifo,
    output logic           txd_o,
    output logic           busy_o,
    output logic           frame_done_o
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 tick;
    logic                 baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign baud_clear = (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear_i(baud_clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_en_i && !fifo.fifo_empty) state_d = StFetch;
            end
            StFetch: state_d = StWait;
            StWait: begin
                if (fifo.fifo_valid) begin
                    shift_d = fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d = ^fifo.fifo_data;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IdxLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
                if (tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so txd_q lines up with state_q.
    always_comb begin
        txd_d = IDLE_LEVEL;
        unique case (state_d)
            StStart:  txd_d = START_LEVEL;
            StData:   txd_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: txd_d = parity_q;
`endif
            default:  txd_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo.fifo_r_en = (state_q == StFetch);
    assign busy_o         = (state_q != StIdle);
    assign frame_done_o   = (state_q == StStop) && tick;
    assign txd_o          = txd_q;

endmodule
